pipe_addsub: RTL and testbench

Parametrised, pipelined add/subtract unit: the successor to the single-cycle ripple-carry add/sub. It splits a W-bit add or subtract into STAGES carry-chained slices, one slice per register stage, so that wide operands meet timing. It carries a valid/ready handshake with backpressure, a pass-through tag, and optional carry/overflow/zero flags. It sits between the issue logic and the writeback bus in execution units that need wide or long-latency-tolerant arithmetic.

---
 rtl/pipe_addsub.sv | 136 +++++++++++++
 tb/tb_pipe_addsub.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// pipe_addsub: W-bit add/subtract split into STAGES carry-chained slices,
// one slice per register stage, with a valid/ready handshake and a tag.
// Define PIPE_ADDSUB_FLAGS_EN to build the carry/overflow/zero flags;
// without it out_cout/out_ovf/out_zero are tied to 0.
module pipe_addsub #(
  parameter int W      = 32,
  parameter int STAGES = 4,
  parameter int TAGW   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_sub,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_sum,
  output logic [TAGW-1:0] out_tag,
  output logic            out_cout,
  output logic            out_ovf,
  output logic            out_zero
);
  localparam int C = W / STAGES;

  logic              adv;
  logic [STAGES-1:0] vld;

`ifdef PIPE_ADDSUB_FLAGS_EN
  logic [W-1:0] last_sum;
  logic         last_cout, last_amsb, last_bmsb;
  logic         cout_q, ovf_q, zero_q;
`endif

  // Whole pipe advances together; only a full, unconsumed last stage stalls it.
  assign adv      = ~vld[STAGES-1] | out_ready;
  assign in_ready = adv;

  // Valid bits shift one stage per advance; bubbles are not squeezed out.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else if (adv) begin
      for (int k = STAGES-1; k > 0; k--) vld[k] <= vld[k-1];
      vld[0] <= in_valid;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [W-1:0]    a_i, b_i, sum_i, sum_n;
    logic            c_i;
    logic [TAGW-1:0] tag_i;
    logic [C:0]      part;
    logic [W-1:0]    sum_q, a_q, b_q;
    logic            c_q;
    logic [TAGW-1:0] tag_q;

    if (k == 0) begin : g_in
      // Subtract is a + ~b + 1: invert b here, carry-in supplies the +1.
      assign a_i   = in_a;
      assign b_i   = in_b ^ {W{in_sub}};
      assign c_i   = in_sub;
      assign sum_i = '0;
      assign tag_i = in_tag;
    end else begin : g_chain
      assign a_i   = g_st[k-1].a_q;
      assign b_i   = g_st[k-1].b_q;
      assign c_i   = g_st[k-1].c_q;
      assign sum_i = g_st[k-1].sum_q;
      assign tag_i = g_st[k-1].tag_q;
    end

    assign part = {1'b0, a_i[k*C +: C]} + {1'b0, b_i[k*C +: C]} + {{C{1'b0}}, c_i};

    // Splice this stage's slice into the partially built sum.
    always_comb begin
      sum_n            = sum_i;
      sum_n[k*C +: C]  = part[C-1:0];
    end

    // Stage registers; contents only matter while the matching valid bit is set.
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q <= '0;
        a_q   <= '0;
        b_q   <= '0;
        c_q   <= 1'b0;
        tag_q <= '0;
      end else if (adv) begin
        sum_q <= sum_n;
        a_q   <= a_i;
        b_q   <= b_i;
        c_q   <= part[C];
        tag_q <= tag_i;
      end
    end

`ifdef PIPE_ADDSUB_FLAGS_EN
    if (k == STAGES-1) begin : g_last
      assign last_sum  = sum_n;
      assign last_cout = part[C];
      assign last_amsb = a_i[W-1];
      assign last_bmsb = b_i[W-1];
    end
`endif
  end

`ifdef PIPE_ADDSUB_FLAGS_EN
  // Flags are formed alongside the last slice so they leave straight from registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      cout_q <= last_cout;
      ovf_q  <= (last_amsb ~^ last_bmsb) & (last_sum[W-1] ^ last_amsb);
      zero_q <= ~|last_sum;
    end
  end

  assign out_cout = cout_q;
  assign out_ovf  = ovf_q;
  assign out_zero = zero_q;
`else
  assign out_cout = 1'b0;
  assign out_ovf  = 1'b0;
  assign out_zero = 1'b0;
`endif

  assign out_valid = vld[STAGES-1];
  assign out_sum   = g_st[STAGES-1].sum_q;
  assign out_tag   = g_st[STAGES-1].tag_q;
endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub (W=32, STAGES=4, TAGW=6): vector table for
// arithmetic/flags/latency, then throughput, backpressure and reset-flush runs.
module tb_pipe_addsub;
  localparam int W = 32, STAGES = 4, TAGW = 6, NV = 9;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, in_sub, out_valid, out_ready;
  logic            out_cout, out_ovf, out_zero;
  logic [W-1:0]    in_a, in_b, out_sum;
  logic [TAGW-1:0] in_tag, out_tag;
  int              n_chk = 0, n_fail = 0;

  typedef struct {
    logic            sub;
    logic [W-1:0]    a, b;
    logic [TAGW-1:0] tag;
    logic [W-1:0]    sum;
    logic            cout, ovf, zero;
  } vec_t;
  vec_t vt [NV];

  always #5 clk = ~clk;

  pipe_addsub #(.W(W), .STAGES(STAGES), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sub(in_sub), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_tag(out_tag), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Flags read as 0 when the flag build option is off.
  function automatic logic fl(input logic f);
`ifdef PIPE_ADDSUB_FLAGS_EN
    return f;
`else
    return 1'b0 & f;
`endif
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [TAGW-1:0] q_tag[$];
    logic [W-1:0]    q_sum[$];
    logic [W-1:0]    held_sum;
    logic [TAGW-1:0] held_tag;
    int issued, retired, j;

    //         sub   a             b             tag  sum           cout ovf  zero
    vt[0] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 6'd5, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[1] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 6'd1, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b1, 32'h80000000, 32'h00000001, 6'd2, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vt[3] = '{1'b1, 32'h00000005, 32'h00000007, 6'd3, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b0, 32'h12345678, 32'h87654321, 6'd4, 32'h99999999, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b1, 32'h00000007, 32'h00000007, 6'd6, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b0, 32'h0000FFFF, 32'h00000001, 6'd7, 32'h00010000, 1'b0, 1'b0, 1'b0};
    vt[7] = '{1'b0, 32'h80000000, 32'h80000000, 6'd8, 32'h00000000, 1'b1, 1'b1, 1'b1};
    vt[8] = '{1'b1, 32'h00000000, 32'h00000001, 6'd9, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_sub = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_sum",   out_sum,   0);
    chk("rst_tag",   out_tag,   0);
    chk("rst_cout",  out_cout,  0);
    chk("rst_ovf",   out_ovf,   0);
    chk("rst_zero",  out_zero,  0);
    chk("rst_ready", in_ready,  1);
    rst = 1'b0; out_ready = 1'b0;
    #1 chk("empty_ready_no_out_ready", in_ready, 1);
    out_ready = 1'b1;
    @(negedge clk);

    // Vector table: one op at a time, latency exactly STAGES edges.
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; in_sub = vt[i].sub; in_a = vt[i].a; in_b = vt[i].b; in_tag = vt[i].tag;
      for (int e = 1; e <= STAGES; e++) begin
        @(negedge clk);
        in_valid = 1'b0;
        if (e < STAGES) chk($sformatf("v%0d_early_valid", i), out_valid, 0);
      end
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_sum", i),   out_sum,   vt[i].sum);
      chk($sformatf("v%0d_tag", i),   out_tag,   vt[i].tag);
      chk($sformatf("v%0d_cout", i),  out_cout,  fl(vt[i].cout));
      chk($sformatf("v%0d_ovf", i),   out_ovf,   fl(vt[i].ovf));
      chk($sformatf("v%0d_zero", i),  out_zero,  fl(vt[i].zero));
    end
    @(negedge clk);

    // Throughput: 8 back-to-back ops, results on 8 consecutive cycles.
    for (int c = 0; c < 8 + STAGES; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; in_sub = 1'b0; in_a = c * 32'h11111111; in_b = 32'h0F0F0F0F;
        in_tag = 6'(c);
      end else in_valid = 1'b0;
      #1 chk($sformatf("tp%0d_in_ready", c), in_ready, 1);
      @(negedge clk);
      j = c + 1 - STAGES;
      if (j >= 0 && j < 8) begin
        chk($sformatf("tp%0d_valid", j), out_valid, 1);
        chk($sformatf("tp%0d_tag", j),   out_tag,   6'(j));
        chk($sformatf("tp%0d_sum", j),   out_sum,   j * 32'h11111111 + 32'h0F0F0F0F);
      end else chk($sformatf("tp_c%0d_idle", c), out_valid, 0);
    end

    // Backpressure: out_ready low for cycles 2..7 while in_valid stays high.
    issued = 0; retired = 0; held_sum = '0; held_tag = '0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 2 && c < 8);
      if (issued < 10) begin
        in_valid = 1'b1; in_tag = 6'(20 + issued);
        in_a = issued * 32'h01000001 + 32'hFF; in_b = 32'h00000F01; in_sub = issued[0];
      end else in_valid = 1'b0;
      #1;
      if (c < 4) chk($sformatf("bp%0d_ready_high", c), in_ready, 1);
      if (c >= 4 && c < 8) chk($sformatf("bp%0d_ready_low", c), in_ready, 0);
      if (c == 4) begin
        chk("bp_full_valid", out_valid, 1);
        held_sum = out_sum; held_tag = out_tag;
      end
      if (c > 4 && c < 8) begin
        chk($sformatf("bp%0d_hold_valid", c), out_valid, 1);
        chk($sformatf("bp%0d_hold_sum", c),   out_sum,   held_sum);
        chk($sformatf("bp%0d_hold_tag", c),   out_tag,   held_tag);
      end
      if (out_valid && out_ready) begin
        if (q_tag.size() == 0) chk("bp_unexpected_result", 1, 0);
        else begin
          chk($sformatf("bp_r%0d_tag", retired), out_tag, q_tag.pop_front());
          chk($sformatf("bp_r%0d_sum", retired), out_sum, q_sum.pop_front());
          retired++;
        end
      end
      if (in_valid && in_ready) begin
        q_tag.push_back(in_tag);
        q_sum.push_back(in_sub ? in_a - in_b : in_a + in_b);
        issued++;
      end
      @(negedge clk);
    end
    chk("bp_retired_count", retired, 10);
    chk("bp_queue_empty", q_tag.size(), 0);

    // Reset with 3 ops in flight: nothing of them may ever come out.
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_sub = 1'b0; in_a = 32'h1000 + c; in_b = 32'h1; in_tag = 6'(40 + c);
      @(negedge clk);
    end
    rst = 1'b1; in_valid = 1'b1; in_a = 32'hDEAD; in_tag = 6'h3F;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_sum",   out_sum,   0);
    chk("mrst_tag",   out_tag,   0);
    chk("mrst_cout",  out_cout,  0);
    chk("mrst_ovf",   out_ovf,   0);
    chk("mrst_zero",  out_zero,  0);
    chk("mrst_ready", in_ready,  1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("mrst_flush%0d", c), out_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
